// File: rtl/vga_text_fetch.sv
// vga_text_fetch: display-side reader for the text-mode VRAM.
// Walks the VRAM read port in step with the VGA timing counters and produces one
// pixel per clk. The screen is COLS x ROWS cells of 8x16 pixels. Character codes are
// stored row-major at TEXT_BASE, and a 128-glyph 8x8 font is stored at FONT_BASE.
// Each font row is shown on two scanlines.
//
// Ports
//   clk         pixel clock, shared with the VRAM read port
//   nrst        asynchronous active-low reset
//   hCount      timing column, 0..H_TOTAL-1
//   vCount      timing line, 0..V_TOTAL-1
//   vramRdAddr  registered VRAM read address
//   vramRdData  VRAM read data, valid the cycle after the address is sampled
//   pixelRgb    registered 3-3-2 pixel colour (1 clk latency)
//   pixelDe     registered display enable for pixelRgb
module vga_text_fetch #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter logic [12:0] TEXT_BASE = 13'h0000,
  parameter logic [12:0] FONT_BASE = 13'h1000,
  parameter logic [7:0]  FG_RGB    = 8'hFF,
  parameter logic [7:0]  BG_RGB    = 8'h00
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [12:0] vramRdAddr,
  input  logic [7:0]  vramRdData,
  output logic [7:0]  pixelRgb,
  output logic        pixelDe
);

  logic [2:0]  phase;
  logic        lastSlot;
  logic [9:0]  fetchCol;
  logic [9:0]  fetchLine;
  logic        live;
  logic        activeNow;
  logic [12:0] textAddr;
  logic [12:0] fontAddr;

  logic [7:0]  chLatch;
  logic [7:0]  nextGlyph;
  logic [7:0]  shiftReg;

  assign phase    = hCount[2:0];
  // The final slot of a line prefetches column 0 of the following line.
  assign lastSlot = (hCount >= 10'(H_TOTAL - 8));

  always_comb begin
    fetchCol  = 10'd0;
    fetchLine = vCount;
    if (lastSlot) begin
      fetchCol  = 10'd0;
      fetchLine = (vCount == 10'(V_TOTAL - 1)) ? 10'd0 : vCount + 10'd1;
    end else begin
      fetchCol  = {3'b000, hCount[9:3]} + 10'd1;
      fetchLine = vCount;
    end
  end

  assign live = (fetchCol < 10'(COLS)) && (fetchLine < 10'(V_ACTIVE)) &&
                ({4'b0000, fetchLine[9:4]} < 10'(ROWS));

  assign activeNow = (hCount < 10'(H_ACTIVE)) && (vCount < 10'(V_ACTIVE));

  assign textAddr = TEXT_BASE + 13'(fetchLine[9:4]) * 13'(COLS) + 13'(fetchCol);
  // Glyph row index is line[3:1] so each font row covers two scanlines.
  assign fontAddr = FONT_BASE + {3'b000, vramRdData[6:0], fetchLine[3:1]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vramRdAddr <= 13'd0;
      chLatch    <= 8'd0;
      nextGlyph  <= 8'd0;
      shiftReg   <= 8'd0;
      pixelRgb   <= 8'd0;
      pixelDe    <= 1'b0;
    end else begin
      pixelDe  <= activeNow;
      pixelRgb <= (activeNow && shiftReg[7]) ? FG_RGB : BG_RGB;

      // Load at the slot boundary so the new glyph's leftmost bit is shown at phase 0.
      if (phase == 3'd7) begin
        shiftReg <= live ? nextGlyph : 8'h00;
      end else begin
        shiftReg <= {shiftReg[6:0], 1'b0};
      end

      if (live) begin
        case (phase)
          3'd0: vramRdAddr <= textAddr;
          3'd2: begin
            chLatch    <= vramRdData;
            vramRdAddr <= fontAddr;
          end
          // Bit 7 of the character code selects inverse video.
          3'd4: nextGlyph <= chLatch[7] ? ~vramRdData : vramRdData;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
module tb_vga_text_fetch;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [9:0]  hCount = 10'd0;
  logic [9:0]  vCount = 10'd0;
  logic [12:0] vramRdAddr;
  logic [7:0]  vramRdData = 8'd0;
  logic [7:0]  pixelRgb;
  logic        pixelDe;

  logic [7:0] mem [0:8191];

  typedef struct {
    int          h;
    int          v;
    logic [7:0]  rgb;
    logic        de;
    logic        chkAddr;
    logic [12:0] addr;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   addr479;

  vga_text_fetch dut (
    .clk        (clk),
    .nrst       (nrst),
    .hCount     (hCount),
    .vCount     (vCount),
    .vramRdAddr (vramRdAddr),
    .vramRdData (vramRdData),
    .pixelRgb   (pixelRgb),
    .pixelDe    (pixelDe)
  );

  always #5 clk = ~clk;

  // Synchronous-read VRAM model.
  always @(posedge clk) vramRdData <= mem[vramRdAddr];

  // Reference: the pixel at (h,v) from the cell/glyph it lies in.
  function automatic logic [7:0] refPixel(int h, int v);
    logic [7:0] ch;
    logic [7:0] g;
    if (h >= 640 || v >= 480) return 8'h00;
    ch = mem[(v / 16) * 80 + h / 8];
    g  = mem[4096 + (ch % 128) * 8 + (v % 16) / 2];
    if (ch >= 8'd128) g = ~g;
    return g[7 - (h % 8)] ? 8'hFF : 8'h00;
  endfunction

  // Expected address after the edge that ends cycle (h,v); returns 0 when unchecked.
  function automatic logic refAddr(int h, int v, output logic [12:0] a);
    int col;
    int line;
    a = 13'd0;
    if (h >= 792) begin
      col  = 0;
      line = (v == 524) ? 0 : v + 1;
    end else begin
      col  = h / 8 + 1;
      line = v;
    end
    if (line < 480 && col < 80 && (h % 8 == 0 || h % 8 == 2)) begin
      if (h % 8 == 0) a = 13'((line / 16) * 80 + col);
      else a = 13'(4096 + (mem[(line / 16) * 80 + col] % 128) * 8 + (line % 16) / 2);
      return 1'b1;
    end
    // Blank lines: address holds the last live fetch (line 479, col 79).
    if (v >= 480 && !(v == 524 && h >= 792) && (h % 50 == 0)) begin
      a = 13'(addr479);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic driveCycle(int h, int v);
    exp_t e;
    logic [12:0] a;
    @(negedge clk);
    hCount = 10'(h);
    vCount = 10'(v);
    e.h       = h;
    e.v       = v;
    e.de      = (h < 640 && v < 480);
    e.rgb     = refPixel(h, v);
    e.chkAddr = refAddr(h, v, a);
    e.addr    = a;
    sbQ.push_back(e);
  endtask

  task automatic runLine(int line);
    int prev;
    prev = (line == 0) ? 524 : line - 1;
    for (int h = 792; h < 800; h++) driveCycle(h, prev);
    for (int h = 0; h < 800; h++) driveCycle(h, line);
  endtask

  task automatic checkZero(string name);
    checks++;
    if (vramRdAddr !== 13'd0 || pixelRgb !== 8'd0 || pixelDe !== 1'b0) begin
      errors++;
      $display("FAIL %s: addr=%h rgb=%h de=%b, required all zero", name, vramRdAddr,
               pixelRgb, pixelDe);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sbQ.size());
    end
  endtask

  // Monitor: one output per clk, compared against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sbQ.size() > 0) begin
      mon = sbQ.pop_front();
      checks++;
      if (pixelDe !== mon.de || pixelRgb !== mon.rgb) begin
        errors++;
        $display("FAIL pixel h=%0d v=%0d: de=%b rgb=%h, required de=%b rgb=%h", mon.h, mon.v,
                 pixelDe, pixelRgb, mon.de, mon.rgb);
      end
      if (mon.chkAddr) begin
        checks++;
        if (vramRdAddr !== mon.addr) begin
          errors++;
          $display("FAIL addr h=%0d v=%0d: addr=%h, required %h", mon.h, mon.v, vramRdAddr,
                   mon.addr);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0]              = 8'h41;
    mem[4096 + 8'h41 * 8] = 8'hA5;
    mem[1]              = 8'hC1;
    mem[162]            = 8'h05;
    addr479 = 4096 + (mem[29 * 80 + 79] % 128) * 8 + 7;

    // Reset held with counters mid-frame.
    hCount = 10'd300;
    vCount = 10'd100;
    repeat (3) @(negedge clk);
    checkZero("reset_initial");
    @(negedge clk);
    hCount = 10'd640;
    vCount = 10'd500;
    nrst   = 1'b1;

    for (int k = 0; k < 4; k++) runLine(4 + $urandom_range(0, 460));
    runLine(0);
    runLine(1);
    runLine(2);
    runLine(3);
    runLine(16);
    runLine(35);
    runLine(479);
    runLine(480);
    runLine(500);
    runLine(524);
    runLine(0);
    drain();

    // Asynchronous reset mid-line, away from a clock edge.
    @(negedge clk);
    hCount = 10'd100;
    vCount = 10'd40;
    #2;
    nrst = 1'b0;
    #1;
    checkZero("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hCount = 10'(101 + i);
    end
    #1;
    checkZero("reset_held");
    hCount = 10'd640;
    vCount = 10'd500;
    @(negedge clk);
    nrst = 1'b1;

    runLine(0);
    runLine(17);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
